// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the round-robin FIFO pop scheduler.
// Holds the scheduler state encoding and the wrapping pointer increment.
package fifo_sched_pkg;

   typedef enum logic {
      SCHED_IDLE  = 1'b0,
      SCHED_BURST = 1'b1
   } sched_state_t;

   // Increment with an explicit wrap so non-power-of-2 queue counts stay in range
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set request at or after start_i,
// wrapping at N-1 -> 0. Reusable by any round-robin arbiter.
module rr_priority_pick #(
   parameter  int unsigned N     = 4,
   localparam int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] start_i,
   output logic             found_o,
   output logic [IDX_W-1:0] grant_idx_o
);

   int unsigned cand;
   logic        hit;

   always_comb begin
      cand        = 0;
      hit         = 1'b0;
      grant_idx_o = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = 32'(start_i) + i;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (!hit && req_i[IDX_W'(cand)]) begin
            hit         = 1'b1;
            grant_idx_o = IDX_W'(cand);
         end
      end
      found_o = hit;
   end

endmodule

// File: rtl/fifo_rr_sched.sv
// Round-robin pop scheduler draining a bank of show-ahead FIFOs into one
// registered valid/ready stream, with a bounded burst per grant.
module fifo_rr_sched
   import fifo_sched_pkg::*;
#(
   parameter  int unsigned NUM_QUEUES  = 4,
   parameter  int unsigned WIDTH       = 32,
   parameter  type         DATA_TYPE_t = logic [WIDTH-1:0],
   parameter  int unsigned MAX_BURST   = 4,
   localparam int unsigned ID_W        = $clog2(NUM_QUEUES),
   localparam int unsigned CNT_W       = $clog2(MAX_BURST + 1)
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic [NUM_QUEUES-1:0] i_fifo_empty,
   input  DATA_TYPE_t            i_fifo_data_out [NUM_QUEUES],
   input  logic [NUM_QUEUES-1:0] i_queue_enable,
   output logic [NUM_QUEUES-1:0] o_fifo_pop,
   output DATA_TYPE_t            o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [ID_W-1:0]       o_grant_id,
   output logic                  o_busy
);

   sched_state_t          state_q, state_d;
   logic [ID_W-1:0]       grant_q, grant_d;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   DATA_TYPE_t            data_q, data_d;
   logic                  valid_q, valid_d;
   logic [NUM_QUEUES-1:0] eligible;
   logic [NUM_QUEUES-1:0] pop_c;
   logic                  slot_free;
   logic                  grant_elig;
   logic                  pick_found;
   logic [ID_W-1:0]       pick_idx;

   assign eligible   = i_queue_enable & ~i_fifo_empty;
   assign slot_free  = ~valid_q | i_ready;
   assign grant_elig = eligible[grant_q];

   rr_priority_pick #(
      .N (NUM_QUEUES)
   ) u_pick (
      .req_i       (eligible),
      .start_i     (rr_ptr_q),
      .found_o     (pick_found),
      .grant_idx_o (pick_idx)
   );

   // Next-state, pop strobe and output-register update
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      valid_d  = valid_q;
      pop_c    = '0;

      case (state_q)
         SCHED_IDLE: begin
            if (slot_free) begin
               valid_d = 1'b0;
            end
            if (pick_found) begin
               grant_d = pick_idx;
               cnt_d   = '0;
               state_d = SCHED_BURST;
            end
         end
         SCHED_BURST: begin
            if (slot_free) begin
               if (grant_elig) begin
                  pop_c[grant_q] = 1'b1;
                  data_d         = i_fifo_data_out[grant_q];
                  valid_d        = 1'b1;
                  cnt_d          = cnt_q + CNT_W'(1);
                  if (cnt_d == CNT_W'(MAX_BURST)) begin
                     state_d  = SCHED_IDLE;
                     rr_ptr_d = ID_W'(rr_next(32'(grant_q), NUM_QUEUES));
                  end
               end else begin
                  // Queue drained or disabled: release at this free slot
                  valid_d  = 1'b0;
                  state_d  = SCHED_IDLE;
                  rr_ptr_d = ID_W'(rr_next(32'(grant_q), NUM_QUEUES));
               end
            end
         end
         default: begin
            state_d = SCHED_IDLE;
         end
      endcase

      if (i_reset) begin
         pop_c = '0;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q  <= SCHED_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
      end
   end

   assign o_fifo_pop = pop_c;
   assign o_data     = data_q;
   assign o_valid    = valid_q;
   assign o_grant_id = grant_q;
   assign o_busy     = (state_q == SCHED_BURST);

endmodule
